// File: rtl/pipe_scroller.sv
// pipe_scroller: spawns pipe obstacles at the right matrix edge with a random
// gap row, scrolls them left one column per game tick, retires them at
// column 0, and optionally counts pipes passed by the dot.
// Optional feature macro: PIPE_SCORE_EN (score counter and score_pulse).
module pipe_scroller #(
   parameter int unsigned N_SLOTS = 3,
   parameter int unsigned X_MAX   = 7,
   parameter int unsigned SPACING = 4,
   parameter int unsigned BIRD_X  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   tick,
   input  logic                   freeze,
   input  logic [3:0]             rnd,
   output logic [N_SLOTS-1:0]     pipe_vld,
   output logic [3*N_SLOTS-1:0]   pipe_x,
   output logic [3*N_SLOTS-1:0]   pipe_gap,
   output logic                   score_pulse,
   output logic [7:0]             score,
   output logic                   running
);

   localparam int unsigned XW = 3;
   localparam int unsigned CW = 4;
   localparam int unsigned SW = 8;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_e;

   state_e                  state_q, state_d;
   logic [N_SLOTS-1:0]      vld_q, vld_d;
   logic [XW*N_SLOTS-1:0]   x_q, x_d;
   logic [XW*N_SLOTS-1:0]   gap_q, gap_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    running_q, running_d;
   logic                    step_c;
   logic                    clear_c;
   logic                    spawned_c;
   logic [2:0]              g_c;
   logic [2:0]              gap_new_c;
   logic                    unused_rnd_c;

   // A game step only happens in RUN on an unfrozen tick; start in HALT wipes the field
   assign step_c  = (state_q == S_RUN) && tick && !freeze;
   assign clear_c = (state_q == S_HALT) && start;

   // Fold the random word onto rows 0..5 so the 3-row gap always fits
   assign g_c          = rnd[2:0];
   assign gap_new_c    = (g_c > 3'd5) ? (g_c - 3'd3) : g_c;
   assign unused_rnd_c = rnd[3];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)  state_d = S_RUN;
         S_RUN:   if (freeze) state_d = S_HALT;
         S_HALT:  if (start)  state_d = S_RUN;
         default:             state_d = S_IDLE;
      endcase
   end

   // Slot move/retire/spawn and spawn-spacing counter for the next cycle
   always_comb begin
      vld_d     = vld_q;
      x_d       = x_q;
      gap_d     = gap_q;
      cnt_d     = cnt_q;
      spawned_c = 1'b0;
      running_d = (state_d == S_RUN);
      if (clear_c) begin
         vld_d = '0;
         x_d   = '0;
         gap_d = '0;
         cnt_d = '0;
      end else if (step_c) begin
         for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (vld_q[i]) begin
               if (x_q[XW*i +: XW] == '0) vld_d[i] = 1'b0;
               else x_d[XW*i +: XW] = x_q[XW*i +: XW] - XW'(1);
            end
         end
         if (cnt_q == '0) begin
            // Only slots free before this tick qualify; a slot retiring now waits
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
               if (!spawned_c && !vld_q[i]) begin
                  vld_d[i]            = 1'b1;
                  x_d[XW*i +: XW]     = XW'(X_MAX);
                  gap_d[XW*i +: XW]   = gap_new_c;
                  spawned_c           = 1'b1;
               end
            end
            if (spawned_c) cnt_d = CW'(SPACING - 1);
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

   // Slot and status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q     <= '0;
         x_q       <= '0;
         gap_q     <= '0;
         cnt_q     <= '0;
         running_q <= 1'b0;
      end else begin
         vld_q     <= vld_d;
         x_q       <= x_d;
         gap_q     <= gap_d;
         cnt_q     <= cnt_d;
         running_q <= running_d;
      end
   end

   assign pipe_vld = vld_q;
   assign pipe_x   = x_q;
   assign pipe_gap = gap_q;
   assign running  = running_q;

`ifdef PIPE_SCORE_EN
   logic [SW-1:0] score_q, score_d;
   logic          pulse_q, pulse_d;
   logic          cross_c;

   // A pipe is passed when it steps from the dot column to the one left of it
   always_comb begin
      cross_c = 1'b0;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
         if (vld_q[i] && (x_q[XW*i +: XW] == XW'(BIRD_X))) cross_c = 1'b1;
      end
   end

   // Score counter next value and one-cycle pass pulse
   always_comb begin
      score_d = score_q;
      pulse_d = 1'b0;
      if (clear_c) begin
         score_d = '0;
      end else if (step_c && cross_c) begin
         score_d = score_q + SW'(1);
         pulse_d = 1'b1;
      end
   end

   // Score registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         score_q <= '0;
         pulse_q <= 1'b0;
      end else begin
         score_q <= score_d;
         pulse_q <= pulse_d;
      end
   end

   assign score       = score_q;
   assign score_pulse = pulse_q;
`else
   logic unused_bird_c;
   assign unused_bird_c = ^SW'(BIRD_X);
   assign score         = '0;
   assign score_pulse   = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_scroller.sv
// Randomized self-checking bench for pipe_scroller: two instances (3 slots and
// 2 slots) share stimulus and are compared every cycle with a slot-list model.
module tb_pipe_scroller;

`ifdef PIPE_SCORE_EN
   localparam bit SCORE_EN = 1'b1;
`else
   localparam bit SCORE_EN = 1'b0;
`endif
   localparam int XM = 7;
   localparam int SP = 4;
   localparam int BX = 2;
   localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, tick = 1'b0, freeze = 1'b0;
   logic [3:0] rnd = 4'd0;

   logic [2:0] vld0;  logic [8:0] x0, gap0;  logic [7:0] score0;  logic pulse0, run0;
   logic [1:0] vld1;  logic [5:0] x1, gap1;  logic [7:0] score1;  logic pulse1, run1;

   pipe_scroller #(.N_SLOTS(3), .X_MAX(XM), .SPACING(SP), .BIRD_X(BX)) u0 (
      .clk(clk), .rst(rst), .start(start), .tick(tick), .freeze(freeze), .rnd(rnd),
      .pipe_vld(vld0), .pipe_x(x0), .pipe_gap(gap0),
      .score_pulse(pulse0), .score(score0), .running(run0));

   pipe_scroller #(.N_SLOTS(2), .X_MAX(XM), .SPACING(SP), .BIRD_X(BX)) u1 (
      .clk(clk), .rst(rst), .start(start), .tick(tick), .freeze(freeze), .rnd(rnd),
      .pipe_vld(vld1), .pipe_x(x1), .pipe_gap(gap1),
      .score_pulse(pulse1), .score(score1), .running(run1));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: per instance a list of slots plus mode, spawn countdown and score
   int m_mode[2];
   int m_vld[2][3];
   int m_x[2][3];
   int m_gap[2][3];
   int m_cnt[2];
   int m_score[2];
   int m_pulse[2];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d @%0t", name, act, exp, $time);
      end
   endtask

   function automatic int fld(input logic [8:0] v, input int i);
      return int'((v >> (3 * i)) & 9'd7);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = M_IDLE; m_cnt[k] = 0; m_score[k] = 0; m_pulse[k] = 0;
         for (int i = 0; i < 3; i++) begin
            m_vld[k][i] = 0; m_x[k][i] = 0; m_gap[k][i] = 0;
         end
      end
   endtask

   task automatic model_step(input bit s, input bit t, input bit f, input logic [3:0] r);
      for (int k = 0; k < 2; k++) begin
         int n = (k == 0) ? 3 : 2;
         m_pulse[k] = 0;
         if (m_mode[k] == M_RUN && t && !f) begin
            int free_slot = -1;
            int g = int'(r) % 8;
            for (int i = n - 1; i >= 0; i--) if (m_vld[k][i] == 0) free_slot = i;
            for (int i = 0; i < n; i++) begin
               if (m_vld[k][i] != 0) begin
                  if (m_x[k][i] == 0) m_vld[k][i] = 0;
                  else begin
                     if (SCORE_EN && m_x[k][i] == BX) begin
                        m_score[k] = (m_score[k] + 1) % 256;
                        m_pulse[k] = 1;
                     end
                     m_x[k][i] = m_x[k][i] - 1;
                  end
               end
            end
            if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
            else if (free_slot >= 0) begin
               m_vld[k][free_slot] = 1;
               m_x[k][free_slot]   = XM;
               m_gap[k][free_slot] = (g > 5) ? g - 3 : g;
               m_cnt[k] = SP - 1;
            end
         end else if (m_mode[k] == M_HALT && s) begin
            m_cnt[k] = 0; m_score[k] = 0;
            for (int i = 0; i < 3; i++) begin
               m_vld[k][i] = 0; m_x[k][i] = 0; m_gap[k][i] = 0;
            end
         end
         if (m_mode[k] == M_IDLE && s) m_mode[k] = M_RUN;
         else if (m_mode[k] == M_RUN && f) m_mode[k] = M_HALT;
         else if (m_mode[k] == M_HALT && s) m_mode[k] = M_RUN;
      end
   endtask

   // Every-cycle comparison of both instances against the model
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u0.vld[%0d]", i), int'(vld0[i]), m_vld[0][i]);
         chk($sformatf("u0.x[%0d]", i),   fld(x0, i),     m_x[0][i]);
         chk($sformatf("u0.gap[%0d]", i), fld(gap0, i),   m_gap[0][i]);
      end
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("u1.vld[%0d]", i), int'(vld1[i]),   m_vld[1][i]);
         chk($sformatf("u1.x[%0d]", i),   fld(9'(x1), i),  m_x[1][i]);
         chk($sformatf("u1.gap[%0d]", i), fld(9'(gap1), i), m_gap[1][i]);
      end
      chk("u0.score", int'(score0), m_score[0]);
      chk("u1.score", int'(score1), m_score[1]);
      chk("u0.pulse", int'(pulse0), m_pulse[0]);
      chk("u1.pulse", int'(pulse1), m_pulse[1]);
      chk("u0.running", int'(run0), (m_mode[0] == M_RUN) ? 1 : 0);
      chk("u1.running", int'(run1), (m_mode[1] == M_RUN) ? 1 : 0);
   end

   task automatic do_cycle(input bit s, input bit t, input bit f, input logic [3:0] r);
      start = s; tick = t; freeze = f; rnd = r;
      @(posedge clk);
      model_step(s, t, f, r);
      @(negedge clk);
      start = 1'b0; tick = 1'b0; freeze = 1'b0;
   endtask

   initial begin
      int live;
      model_reset();
      repeat (2) @(negedge clk);
      chk("lit.reset_vld", int'(vld0), 0);
      chk("lit.reset_run", int'(run0), 0);
      rst = 1'b0;

      // Ticks in IDLE are dropped
      do_cycle(1'b0, 1'b1, 1'b0, 4'(($urandom)));
      do_cycle(1'b0, 1'b1, 1'b0, 4'(($urandom)));
      chk("lit.idle_vld", int'(vld0), 0);

      do_cycle(1'b1, 1'b0, 1'b0, 4'd0);
      chk("lit.start_run", int'(run0), 1);

      // Directed trajectory: 12 ticks, each followed by an idle cycle
      for (int k = 1; k <= 12; k++) begin
         do_cycle(1'b0, 1'b1, 1'b0, (k == 1) ? 4'b0110 : 4'($urandom));
         if (k == 1) begin
            chk("lit.t1_vld", int'(vld0), 1);
            chk("lit.t1_x0", fld(x0, 0), 7);
            chk("lit.t1_gap0", fld(gap0, 0), 3);
         end
         if (k == 5) begin
            chk("lit.t5_vld", int'(vld0), 3);
            chk("lit.t5_x1", fld(x0, 1), 7);
            chk("lit.t5_x0", fld(x0, 0), 3);
         end
         if (k == 7) chk("lit.t7_score", int'(score0), SCORE_EN ? 1 : 0);
         if (k == 8) chk("lit.t8_x0", fld(x0, 0), 0);
         if (k == 9) begin
            chk("lit.t9_vld", int'(vld0), 6);
            chk("lit.t9_x2", fld(x0, 2), 7);
            chk("lit.t9_u1vld", int'(vld1), 2);
         end
         if (k == 10) begin
            chk("lit.t10_u1vld", int'(vld1), 3);
            chk("lit.t10_u1x0", fld(9'(x1), 0), 7);
         end
         if (k == 12) chk("lit.t12_score", int'(score0), SCORE_EN ? 2 : 0);
         do_cycle(1'b0, 1'b0, 1'b0, 4'd0);
      end

      // Freeze with tick: no step, go to HALT; ticks are then dropped
      do_cycle(1'b0, 1'b1, 1'b1, 4'($urandom));
      chk("lit.frz_run", int'(run0), 0);
      repeat (3) do_cycle(1'b0, 1'b1, 1'b0, 4'($urandom));
      do_cycle(1'b1, 1'b0, 1'b0, 4'd0);
      chk("lit.restart_vld", int'(vld0), 0);
      chk("lit.restart_score", int'(score0), 0);
      do_cycle(1'b0, 1'b1, 1'b0, 4'b0111);
      chk("lit.restart_x0", fld(x0, 0), 7);
      chk("lit.restart_gap0", fld(gap0, 0), 4);

      // Randomized phase
      for (int c = 0; c < 600; c++) begin
         do_cycle(($urandom % 16) == 0, ($urandom % 2) == 0,
                  ($urandom % 40) == 0, 4'($urandom));
      end

      // Async reset mid-run with at least two pipes live
      if (m_mode[0] != M_RUN) do_cycle(1'b1, 1'b0, 1'b0, 4'd0);
      live = 0;
      for (int c = 0; c < 30 && live < 2; c++) begin
         do_cycle(1'b0, 1'b1, 1'b0, 4'($urandom));
         live = m_vld[0][0] + m_vld[0][1] + m_vld[0][2];
      end
      chk("lit.live_before_rst", (live >= 2) ? 1 : 0, 1);
      #2 rst = 1'b1;
      #1;
      chk("lit.arst_vld", int'(vld0), 0);
      chk("lit.arst_x", int'(x0), 0);
      chk("lit.arst_gap", int'(gap0), 0);
      chk("lit.arst_score", int'(score0), 0);
      chk("lit.arst_run", int'(run0), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      do_cycle(1'b0, 1'b1, 1'b0, 4'($urandom));
      chk("lit.post_rst_idle", int'(vld0), 0);
      do_cycle(1'b1, 1'b0, 1'b0, 4'd0);
      do_cycle(1'b0, 1'b1, 1'b0, 4'd5);
      chk("lit.post_rst_gap", fld(gap0, 0), 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_scroller.md
# pipe_scroller

Obstacle generator stage directly downstream of the 4-bit LFSR random source. Consumes the LFSR's `rnd[3:0]` word, spawns pipe obstacles at the right edge of the LED matrix with a random gap row, scrolls them left one column per game tick, retires them at column 0, and counts pipes passed by the dot. Its outputs feed the display composer and the collision checker.

## Interface
Parameters:
- `N_SLOTS`, 3: number of concurrent pipe slots (1..4).
- `X_MAX`, 7: spawn column, i.e. the rightmost matrix column (3-bit x).
- `SPACING`, 4: ticks between successive spawns (2..8).
- `BIRD_X`, 2: column the dot occupies (1..X_MAX).

Ports (clock and reset first):
- `clk` in 1: single system clock; all state on the posedge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level-sampled; IDLE→RUN and HALT→RUN (clears field).
- `tick` in 1: one-cycle game-step strobe.
- `freeze` in 1: collision/hold request from the collision checker.
- `rnd` in 4: LFSR output, sampled only on a spawning tick.
- `pipe_vld` out N_SLOTS: slot-occupied flags.
- `pipe_x` out 3*N_SLOTS: column per slot; slot i at [3i+2:3i].
- `pipe_gap` out 3*N_SLOTS: gap top row per slot; the gap covers rows gap..gap+2.
- `score_pulse` out 1: one-cycle pulse per pipe passed.
- `score` out 8: pipes passed, wraps 255→0.
- `running` out 1: high in RUN.

## Operation
- FSM states: IDLE, RUN, HALT. Reset → IDLE.
  - IDLE: field empty; `start`=1 → RUN.
  - RUN: `freeze`=1 → HALT; `start` is ignored.
  - HALT: all state is held; `start`=1 → RUN, clears all slots, `score`, and `spawn_cnt`.
- Reset values: `pipe_vld`=0, `pipe_x`=0, `pipe_gap`=0, `score`=0, `score_pulse`=0, `running`=0, `spawn_cnt`=0.
- Tick processing happens only in RUN, on a cycle with `tick`=1 and `freeze`=0. The following all take effect at the same clock edge:
  - Move: each valid slot with x>0 does x←x-1; a valid slot with x=0 clears its `vld` (retire).
  - Score: each slot whose x goes from BIRD_X to BIRD_X-1 increments `score` by 1, and `score_pulse` is asserted on the next cycle. Multiple crossings on the same tick are impossible with SPACING≥2.
  - Spawn: if `spawn_cnt`=0 and a slot was free before this tick, the lowest-index free slot gets x=X_MAX, gap=f(rnd), vld=1, and `spawn_cnt` reloads to SPACING-1.
    - If no slot is free, the spawn is deferred: `spawn_cnt` stays 0 and the spawn is retried on every later tick.
    - A slot retired on this tick is not reusable until the next tick.
  - Otherwise, if `spawn_cnt`≠0, it decrements.
- Gap mapping: g=`rnd[2:0]`; gap = (g>5) ? g-3 : g. Range 0..5. `rnd[3]` is unused.
- The first tick after entering RUN spawns immediately, because `spawn_cnt` is 0.
- `freeze` and `tick` in the same cycle: `freeze` wins, with no move, spawn, or score.

## Timing
- All outputs are registered. Tick effects are visible in the cycle after the `tick` edge.
- `score_pulse` is high for exactly one cycle, one cycle after the crossing tick is sampled.
- `running` follows the state register: high in the cycle after the transition into RUN.
- Reset is asynchronous. Asserting it mid-RUN forces the reset values immediately, independent of `clk`.
- Ticks arriving while in IDLE or HALT are dropped, not queued.

## Configuration
- `PIPE_SCORE_EN` defined: the score counter and `score_pulse` are implemented as described above.
- `PIPE_SCORE_EN` undefined: `score` is tied to 8'd0 and `score_pulse` to 0, and no crossing logic is synthesized. All other behaviour is identical.

## Test plan
- Reset then start, with rnd=4'b0110 on tick 1: slot0 vld=1, x=7, gap=3 (6>5 → 3). slots 1-2 are empty. `spawn_cnt`=3.
- 8 ticks after the first spawn (default parameters): slot0 x goes 7→0, then retires on tick 9. Slot1 spawns on tick 5 and slot2 on tick 9, at x=7. `score` increments when slot0 x moves 2→1, and `score_pulse` is seen exactly once per pipe.
- With N_SLOTS=2, SPACING=4: the spawn due on tick 9 is deferred, because slot0 retires that same tick. The spawn lands in slot0 on tick 10, and the next spawn follows 4 ticks later.
- `freeze`=1 together with `tick` in RUN: no movement and state goes to HALT. Further ticks change nothing. `start` then clears the field, sets score=0, and the next tick spawns a pipe at x=7.
- Assert `rst` mid-RUN, between clock edges, with 2 pipes live and score=5: all outputs drop to 0 before the next posedge, and the state is IDLE.
- Built without `PIPE_SCORE_EN`: repeat scenario 2; `score` stays 0 and `score_pulse` never asserts, while the slot trajectories are unchanged.
